// File: rtl/change_dispenser_ctrl.sv
// Change dispenser controller: pays a refund through a coin hopper using a
// greedy 50/10/5 sequence with a req/ack handshake, an ack timeout, an
// inter-coin gap and per-denomination stock counters.
// Optional: define CHANGE_AUDIT_EN to add a 16-bit running total of paid coins.
module change_dispenser_ctrl #(
  parameter int unsigned INIT_STOCK_50 = 4,
  parameter int unsigned INIT_STOCK_10 = 10,
  parameter int unsigned INIT_STOCK_5  = 10,
  parameter int unsigned ACK_TIMEOUT   = 200,
  parameter int unsigned GAP_CYCLES    = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refund_req,
  input  logic [9:0] refund_amount,
  input  logic       coin_ack,
  input  logic       add_50,
  input  logic       add_10,
  input  logic       add_5,
  output logic       eject_req,
  output logic [1:0] eject_sel,
  output logic       busy,
  output logic       done,
  output logic       shortfall,
  output logic       fault,
  output logic [9:0] remaining,
  output logic [7:0] stock_50,
  output logic [7:0] stock_10,
  output logic [7:0] stock_5
`ifdef CHANGE_AUDIT_EN
  ,
  output logic [15:0] total_paid
`endif
);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FINISH} state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_5    = 2'b01;
  localparam logic [1:0] SEL_10   = 2'b10;
  localparam logic [1:0] SEL_50   = 2'b11;

  state_t      state;
  logic [31:0] cnt;
  logic        ack_hit;
  logic        dec_50, dec_10, dec_5;
  logic [9:0]  coin_value;

  // Saturating stock step; a simultaneous add and eject cancel out.
  function automatic logic [7:0] next_stock(input logic [7:0] s,
                                            input logic inc,
                                            input logic dec);
    logic [7:0] r;
    r = s;
    if (inc && !dec) begin
      if (s != 8'hFF) r = s + 8'd1;
    end else if (dec && !inc) begin
      r = s - 8'd1;
    end
    return r;
  endfunction

  // Decode an accepted coin acknowledgement and the value of that coin.
  always_comb begin
    ack_hit = (state == EJECT) && coin_ack;
    dec_50  = ack_hit && (eject_sel == SEL_50);
    dec_10  = ack_hit && (eject_sel == SEL_10);
    dec_5   = ack_hit && (eject_sel == SEL_5);
    case (eject_sel)
      SEL_50:  coin_value = 10'd50;
      SEL_10:  coin_value = 10'd10;
      SEL_5:   coin_value = 10'd5;
      default: coin_value = 10'd0;
    endcase
  end

  // Refund sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      eject_req <= 1'b0;
      eject_sel <= SEL_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      shortfall <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
    end else begin
      done      <= 1'b0;
      shortfall <= 1'b0;
      case (state)
        IDLE: begin
          if (refund_req) begin
            remaining <= refund_amount;
            fault     <= 1'b0;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          cnt <= '0;
          if (remaining == 10'd0) begin
            done  <= 1'b1;
            state <= FINISH;
          end else if (remaining >= 10'd50 && stock_50 != 8'd0) begin
            eject_sel <= SEL_50;
            eject_req <= 1'b1;
            state     <= EJECT;
          end else if (remaining >= 10'd10 && stock_10 != 8'd0) begin
            eject_sel <= SEL_10;
            eject_req <= 1'b1;
            state     <= EJECT;
          end else if (remaining >= 10'd5 && stock_5 != 8'd0) begin
            eject_sel <= SEL_5;
            eject_req <= 1'b1;
            state     <= EJECT;
          end else begin
            done      <= 1'b1;
            shortfall <= 1'b1;
            state     <= FINISH;
          end
        end
        EJECT: begin
          if (coin_ack) begin
            remaining <= remaining - coin_value;
            eject_req <= 1'b0;
            eject_sel <= SEL_NONE;
            cnt       <= '0;
            state     <= GAP;
          end else if (cnt == ACK_TIMEOUT - 1) begin
            fault     <= 1'b1;
            eject_req <= 1'b0;
            eject_sel <= SEL_NONE;
            done      <= 1'b1;
            shortfall <= (remaining != 10'd0);
            state     <= FINISH;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_CYCLES - 1) begin
            state <= SELECT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Coin stock counters: refilled by inserted coins, drained by acked ejects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stock_50 <= 8'(INIT_STOCK_50);
      stock_10 <= 8'(INIT_STOCK_10);
      stock_5  <= 8'(INIT_STOCK_5);
    end else begin
      stock_50 <= next_stock(stock_50, add_50, dec_50);
      stock_10 <= next_stock(stock_10, add_10, dec_10);
      stock_5  <= next_stock(stock_5,  add_5,  dec_5);
    end
  end

`ifdef CHANGE_AUDIT_EN
  // Running total of coin value paid out, wrapping at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_paid <= '0;
    end else if (ack_hit) begin
      total_paid <= total_paid + {6'd0, coin_value};
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Scoreboard bench for change_dispenser_ctrl: stimulus pushes the expected
// coin sequence and refund result; a monitor pops and compares them as the
// DUT starts each eject and pulses done. A hopper model acks each request.
module tb_change_dispenser_ctrl;

  localparam int unsigned TB_ACK_TIMEOUT = 20;
  localparam int unsigned TB_GAP_CYCLES  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       refund_req;
  logic [9:0] refund_amount;
  logic       coin_ack;
  logic       add_50, add_10, add_5;
  logic       eject_req;
  logic [1:0] eject_sel;
  logic       busy, done, shortfall, fault;
  logic [9:0] remaining;
  logic [7:0] stock_50, stock_10, stock_5;
`ifdef CHANGE_AUDIT_EN
  logic [15:0] total_paid;
`endif

  change_dispenser_ctrl #(
    .INIT_STOCK_50(4),
    .INIT_STOCK_10(10),
    .INIT_STOCK_5 (10),
    .ACK_TIMEOUT  (TB_ACK_TIMEOUT),
    .GAP_CYCLES   (TB_GAP_CYCLES)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .refund_req   (refund_req),
    .refund_amount(refund_amount),
    .coin_ack     (coin_ack),
    .add_50       (add_50),
    .add_10       (add_10),
    .add_5        (add_5),
    .eject_req    (eject_req),
    .eject_sel    (eject_sel),
    .busy         (busy),
    .done         (done),
    .shortfall    (shortfall),
    .fault        (fault),
    .remaining    (remaining),
    .stock_50     (stock_50),
    .stock_10     (stock_10),
    .stock_5      (stock_5)
`ifdef CHANGE_AUDIT_EN
    ,
    .total_paid   (total_paid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sf;
    logic [9:0] rem;
    logic       flt;
  } res_t;

  logic [1:0] exp_coin[$];
  res_t       exp_res[$];

  int n_checks = 0;
  int n_errors = 0;

  logic ack_en = 1'b1;
  logic add_on_ack = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_coins(input logic [1:0] sel, input int n);
    for (int i = 0; i < n; i++) exp_coin.push_back(sel);
  endtask

  task automatic push_res(input logic sf, input logic [9:0] rem, input logic flt);
    res_t r;
    r.sf = sf; r.rem = rem; r.flt = flt;
    exp_res.push_back(r);
  endtask

  // Hopper model: ack two cycles after a request is first seen.
  initial begin
    coin_ack = 1'b0;
    add_10   = 1'b0;
    forever begin
      @(negedge clk);
      if (eject_req && ack_en && !reset) begin
        @(negedge clk);
        coin_ack = 1'b1;
        add_10   = add_on_ack && (eject_sel == 2'b10);
        @(negedge clk);
        coin_ack = 1'b0;
        add_10   = 1'b0;
      end
    end
  end

  // Monitor: compare each new eject and each done against the scoreboard.
  initial begin
    logic prev_req;
    logic [1:0] ec;
    res_t er;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (eject_req && !prev_req) begin
        if (exp_coin.size() == 0) begin
          chk("unexpected_eject", int'(eject_sel), 0);
        end else begin
          ec = exp_coin.pop_front();
          chk("eject_sel", int'(eject_sel), int'(ec));
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          er = exp_res.pop_front();
          chk("shortfall", int'(shortfall), int'(er.sf));
          chk("remaining", int'(remaining), int'(er.rem));
          chk("fault", int'(fault), int'(er.flt));
          chk("busy_at_done", int'(busy), 1);
        end
      end
      prev_req = eject_req;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(input logic [9:0] amt);
    @(negedge clk);
    refund_req    = 1'b1;
    refund_amount = amt;
    @(negedge clk);
    refund_req    = 1'b0;
  endtask

  // Wait from the current negedge until done; lat counts negedges since issue.
  task automatic wait_done(output int lat, output int req_seen);
    lat = 1;
    req_seen = 0;
    while (!done && lat < 3000) begin
      if (eject_req) req_seen = 1;
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, rs, hi;
    reset = 1'b1;
    refund_req = 1'b0;
    refund_amount = '0;
    add_50 = 1'b0;
    add_5  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset values.
    chk("rst_eject_req", int'(eject_req), 0);
    chk("rst_eject_sel", int'(eject_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_shortfall", int'(shortfall), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_stock_50", int'(stock_50), 4);
    chk("rst_stock_10", int'(stock_10), 10);
    chk("rst_stock_5", int'(stock_5), 10);

    // 85 -> 50,10,10,10,5.
    push_coins(2'b11, 1); push_coins(2'b10, 3); push_coins(2'b01, 1);
    push_res(1'b0, 10'd0, 1'b0);
    issue(10'd85);
    wait_done(lat, rs);
    chk("s85_stock_50", int'(stock_50), 3);
    chk("s85_stock_10", int'(stock_10), 7);
    chk("s85_stock_5", int'(stock_5), 9);
`ifdef CHANGE_AUDIT_EN
    chk("s85_total_paid", int'(total_paid), 85);
`endif
    @(negedge clk);
    chk("s85_busy_after", int'(busy), 0);

    // Zero amount: done two negedges after issue, never ejects.
    push_res(1'b0, 10'd0, 1'b0);
    issue(10'd0);
    wait_done(lat, rs);
    chk("zero_latency", lat, 2);
    chk("zero_no_eject", rs, 0);

    // add_10 coincident with a 10-coin ack: stock_10 unchanged.
    add_on_ack = 1'b1;
    push_coins(2'b10, 1);
    push_res(1'b0, 10'd0, 1'b0);
    issue(10'd10);
    wait_done(lat, rs);
    add_on_ack = 1'b0;
    chk("add_ack_stock_10", int'(stock_10), 7);

    // Second refund_req while busy is ignored.
    push_coins(2'b10, 3);
    push_res(1'b0, 10'd0, 1'b0);
    issue(10'd30);
    repeat (3) @(negedge clk);
    refund_req = 1'b1;
    refund_amount = 10'd500;
    @(negedge clk);
    refund_req = 1'b0;
    wait_done(lat, rs);
    chk("busy_ignore_stock_10", int'(stock_10), 4);

    // Timeout: eject_req high for exactly ACK_TIMEOUT cycles.
    ack_en = 1'b0;
    push_coins(2'b11, 1);
    push_res(1'b1, 10'd50, 1'b1);
    issue(10'd50);
    hi = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (eject_req) hi++;
      @(negedge clk);
    end
    chk("timeout_done_seen", int'(done), 1);
    chk("timeout_req_cycles", hi, int'(TB_ACK_TIMEOUT));
    chk("timeout_stock_50", int'(stock_50), 3);
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("fault_sticky", int'(fault), 1);

    // A new refund clears fault.
    push_coins(2'b01, 1);
    push_res(1'b0, 10'd0, 1'b0);
    issue(10'd5);
    wait_done(lat, rs);
    chk("s5_stock_5", int'(stock_5), 8);

    // Exhaust stocks, then pay a non-multiple of 5 with shortfall.
    do_reset();
    push_coins(2'b11, 4);
    push_res(1'b0, 10'd0, 1'b0);
    issue(10'd200);
    wait_done(lat, rs);
    chk("drain_stock_50", int'(stock_50), 0);
    push_coins(2'b10, 10); push_coins(2'b01, 4);
    push_res(1'b0, 10'd0, 1'b0);
    issue(10'd120);
    wait_done(lat, rs);
    chk("s120_stock_10", int'(stock_10), 0);
    chk("s120_stock_5", int'(stock_5), 6);
    push_coins(2'b01, 6);
    push_res(1'b1, 10'd7, 1'b0);
    issue(10'd37);
    wait_done(lat, rs);
    chk("s37_stock_5", int'(stock_5), 0);
    @(negedge clk);
    chk("remaining_held", int'(remaining), 7);

    // Asynchronous reset while a request is outstanding.
    do_reset();
    ack_en = 1'b0;
    push_coins(2'b11, 1);
    issue(10'd50);
    for (int i = 0; i < 10 && !eject_req; i++) @(negedge clk);
    chk("pre_reset_eject_req", int'(eject_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_eject_req", int'(eject_req), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_stock_50", int'(stock_50), 4);
    chk("mid_rst_stock_10", int'(stock_10), 10);
    chk("mid_rst_stock_5", int'(stock_5), 10);
`ifdef CHANGE_AUDIT_EN
    chk("mid_rst_total_paid", int'(total_paid), 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    ack_en = 1'b1;

    // Stock saturation and single add.
    add_5 = 1'b1;
    add_50 = 1'b1;
    @(negedge clk);
    add_50 = 1'b0;
    repeat (249) @(negedge clk);
    add_5 = 1'b0;
    @(negedge clk);
    chk("sat_stock_5", int'(stock_5), 255);
    chk("add_stock_50", int'(stock_50), 5);

    repeat (3) @(negedge clk);
    chk("coins_left", exp_coin.size(), 0);
    chk("results_left", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
